mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller; consumes EX/MEM buffer fields written by the execution unit.
- Sequences 16-bit data-memory accesses over a req/ack handshake. Stack PC pushes/pops use two words.
- Produces MEM/WB write-back fields, flag-restore and PC-restore pulses, and a Stall that freezes EX/MEM and all upstream buffers while an access is in flight.

Parameters:
ADDR_W, 12, data-memory word-address width; mem_addr = low ADDR_W bits of computed address.
DATA_W, 16, memory word width; fixed at 16, not re-parameterised elsewhere.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX/MEM buffer holds a live instruction
Data  in  32  EX/MEM Data[31:0]; ALU result, store data or PC to push
WB_Address  in  3  destination register
MR  in  1  memory read
MW  in  1  memory write
WB  in  1  register write-back enable
Address  in  32  EX/MEM Address[69:38]; memory/stack address
JWSP  in  1  call: push PC (two-word write)
Stack_PC  in  1  PC push/pop (two words)
Stack_Flags  in  1  flags push/pop (one word)
Final_Flags  in  3  NF|CF|ZF from EX
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid when mem_ack=1
mem_ack  in  1  access complete this cycle
Stall  out  1  hold EX/MEM and earlier stages
wb_valid  out  1  MEM/WB fields valid (one-cycle pulse per instruction)
WB_Out  out  1  registered WB
WB_Address_Out  out  3  registered WB_Address
WB_Data  out  16  Data[15:0] for non-read ops; mem_rdata for single-word reads
Flags_From_Memory  out  3  popped flags, mem_rdata[2:0]
Flags_Restore  out  1  one-cycle pulse with popped flags
PC_From_Memory  out  32  popped PC
PC_Load  out  1  one-cycle pulse with popped PC

Behaviour:
- Reset: all outputs 0; state IDLE; any in-flight op is dropped; mem_req is low the cycle after the reset edge.
- States: IDLE, ACC0 (first/only word), ACC1 (second word).
- Op classification on accept:
  - mem = MR|MW.
  - dbl = Stack_PC|JWSP.
  - MR&MW together: MW wins, MR ignored.
- IDLE, ex_valid=1, mem=0: no stall. Next edge registers wb_valid=1 and WB/WB_Address/Data[15:0]. Latency is 1 cycle.
- IDLE, ex_valid=1, mem=1: Stall=1 combinationally. Next edge latches the op and enters ACC0. While busy, EX inputs are ignored.
- ACC0: mem_req=1, mem_we=MW.
  - Word order: high half first. Word0 is at Address; word1 is at Address+1 (mod 2^32, wrap allowed). mem_addr is truncated to ADDR_W bits.
  - Write data:
    - dbl: word0 = Data[31:16], word1 = Data[15:0].
    - Stack_Flags: {13'b0, Final_Flags}.
    - Otherwise: Data[15:0].
  - On ack: dbl → ACC1 (req may re-assert the next cycle); otherwise → IDLE.
- ACC1: second word. On ack → IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until the cycle mem_ack=1.
  - Zero-wait ack (same cycle as req) is legal.
  - mem_ack with mem_req=0 is ignored.
- Stall = (IDLE & ex_valid & mem) | (busy & !(final-word ack this cycle)). Stall drops in the final ack cycle so EX/MEM advances on that edge; no re-accept because state is busy in that cycle.
- Completion edge (final ack) registers:
  - wb_valid=1, WB_Out and WB_Address_Out.
  - Pop PC (MR & Stack_PC): PC_From_Memory = {word0, word1}, PC_Load=1.
  - Pop flags (MR & Stack_Flags): Flags_From_Memory = rdata[2:0], Flags_Restore=1.
  - Plain read: WB_Data = rdata.
  - Writes: WB_Data = Data[15:0].
- wb_valid, PC_Load and Flags_Restore are single-cycle pulses.
- WB_Out is forced 0 for stack-PC/flags ops.
- ex_valid=0 in IDLE: no action, wb_valid=0.

Test Plan:
- ALU op Data=32'd15, WB=1, WB_Address=7, MR=MW=0 → Stall never high; next cycle wb_valid=1, WB_Data=15, WB_Address_Out=7.
- Load Address=32'h20, mem_ack 3 cycles after req, rdata=16'hBEEF → mem_addr=12'h020, mem_we=0; Stall high 4 cycles; WB_Data=BEEF, wb_valid pulse.
- JWSP push, Data=32'h0001_0002, Address=32'h3FE, zero-wait ack → writes 0001@3FE then 0002@3FF; Stall high exactly 3 cycles; WB_Out=0.
- Stack_PC pop, Address=32'hFFFF_FFFF, rdata 1234 then 5678 → second mem_addr=0 (wrap); PC_From_Memory=32'h1234_5678, PC_Load one pulse.
- Stack_Flags push with Final_Flags=3'b101, then pop with rdata=16'h0006 → mem_wdata=16'h0005; then Flags_From_Memory=3'b110, Flags_Restore pulse.
- rst asserted while in ACC1 awaiting ack → next cycle mem_req=0, Stall=0, no PC_Load; a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage access sequencer between EX/MEM and MEM/WB
module mem_stage_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       Data,
    input  logic [2:0]        WB_Address,
    input  logic              MR,
    input  logic              MW,
    input  logic              WB,
    input  logic [31:0]       Address,
    input  logic              JWSP,
    input  logic              Stack_PC,
    input  logic              Stack_Flags,
    input  logic [2:0]        Final_Flags,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              Stall,
    output logic              wb_valid,
    output logic              WB_Out,
    output logic [2:0]        WB_Address_Out,
    output logic [DATA_W-1:0] WB_Data,
    output logic [2:0]        Flags_From_Memory,
    output logic              Flags_Restore,
    output logic [31:0]       PC_From_Memory,
    output logic              PC_Load
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              op_rd;
    logic              op_dbl;
    logic              op_pc;
    logic              op_flags;
    logic              op_wb;
    logic [2:0]        op_wba;
    logic [DATA_W-1:0] op_lo;
    logic [ADDR_W-1:0] op_addr1;
    logic [DATA_W-1:0] hi_word;

    logic              is_mem;
    logic              is_dbl;
    logic              stack_op;
    logic              ack_ok;
    logic              last_word;
    logic              final_ack;
    logic [DATA_W-1:0] first_wdata;
    logic              unused_addr_hi;

    assign is_mem         = MR | MW;
    assign is_dbl         = Stack_PC | JWSP;
    assign stack_op       = is_dbl | Stack_Flags;
    assign ack_ok         = mem_req & mem_ack;
    assign last_word      = (state == ACC1) || ((state == ACC0) && !op_dbl);
    assign final_ack      = ack_ok & last_word;
    assign unused_addr_hi = ^Address[31:ADDR_W];

    // Stall releases in the final-ack cycle so EX/MEM advances on the same edge.
    assign Stall = (state == IDLE) ? (ex_valid & is_mem) : !final_ack;

    always_comb begin
        first_wdata = Data[DATA_W-1:0];
        if (is_dbl)
            first_wdata = Data[2*DATA_W-1:DATA_W];
        else if (Stack_Flags)
            first_wdata = {{(DATA_W-3){1'b0}}, Final_Flags};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            wb_valid          <= 1'b0;
            WB_Out            <= 1'b0;
            WB_Address_Out    <= '0;
            WB_Data           <= '0;
            Flags_From_Memory <= '0;
            Flags_Restore     <= 1'b0;
            PC_From_Memory    <= '0;
            PC_Load           <= 1'b0;
            op_rd             <= 1'b0;
            op_dbl            <= 1'b0;
            op_pc             <= 1'b0;
            op_flags          <= 1'b0;
            op_wb             <= 1'b0;
            op_wba            <= '0;
            op_lo             <= '0;
            op_addr1          <= '0;
            hi_word           <= '0;
        end else begin
            wb_valid      <= 1'b0;
            PC_Load       <= 1'b0;
            Flags_Restore <= 1'b0;
            if (final_ack) begin
                state          <= IDLE;
                mem_req        <= 1'b0;
                mem_we         <= 1'b0;
                wb_valid       <= 1'b1;
                WB_Out         <= op_wb;
                WB_Address_Out <= op_wba;
                WB_Data        <= (op_rd && !op_dbl && !op_flags) ? mem_rdata : op_lo;
                if (op_rd && op_pc) begin
                    PC_From_Memory <= {hi_word, mem_rdata};
                    PC_Load        <= 1'b1;
                end
                if (op_rd && op_flags) begin
                    Flags_From_Memory <= mem_rdata[2:0];
                    Flags_Restore     <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (ex_valid && is_mem) begin
                            state     <= ACC0;
                            mem_req   <= 1'b1;
                            mem_we    <= MW;
                            mem_addr  <= Address[ADDR_W-1:0];
                            mem_wdata <= first_wdata;
                            op_rd     <= MR & ~MW;
                            op_dbl    <= is_dbl;
                            op_pc     <= Stack_PC;
                            op_flags  <= Stack_Flags & ~is_dbl;
                            op_wb     <= WB & ~stack_op;
                            op_wba    <= WB_Address;
                            op_lo     <= Data[DATA_W-1:0];
                            op_addr1  <= Address[ADDR_W-1:0] + ADDR_ONE;
                        end else if (ex_valid) begin
                            wb_valid       <= 1'b1;
                            WB_Out         <= WB & ~stack_op;
                            WB_Address_Out <= WB_Address;
                            WB_Data        <= Data[DATA_W-1:0];
                        end
                    end
                    ACC0: begin
                        // First word of a two-word op done; drop req for one cycle before word1.
                        if (ack_ok) begin
                            state     <= ACC1;
                            mem_req   <= 1'b0;
                            hi_word   <= mem_rdata;
                            mem_addr  <= op_addr1;
                            mem_wdata <= op_lo;
                        end
                    end
                    ACC1: begin
                        if (!mem_req)
                            mem_req <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - vector, directed and randomized checks for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] Data;
    logic [2:0]  WB_Address;
    logic        MR, MW, WB;
    logic [31:0] Address;
    logic        JWSP, Stack_PC, Stack_Flags;
    logic [2:0]  Final_Flags;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        Stall;
    logic        wb_valid, WB_Out;
    logic [2:0]  WB_Address_Out;
    logic [15:0] WB_Data;
    logic [2:0]  Flags_From_Memory;
    logic        Flags_Restore;
    logic [31:0] PC_From_Memory;
    logic        PC_Load;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .Data(Data),
        .WB_Address(WB_Address), .MR(MR), .MW(MW), .WB(WB), .Address(Address),
        .JWSP(JWSP), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
        .Final_Flags(Final_Flags), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .Stall(Stall), .wb_valid(wb_valid), .WB_Out(WB_Out),
        .WB_Address_Out(WB_Address_Out), .WB_Data(WB_Data),
        .Flags_From_Memory(Flags_From_Memory), .Flags_Restore(Flags_Restore),
        .PC_From_Memory(PC_From_Memory), .PC_Load(PC_Load)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0]  wba;
        logic        wb, mr, mw, jwsp, spc, sfl;
        logic [2:0]  ff;
    } op_t;

    typedef struct {
        int             n_acc;
        logic [1:0][11:0] a_addr;
        logic [1:0]     a_we;
        logic [1:0][15:0] a_wd;
        int             stall;
        int             n_wbv, n_pcl, n_flr;
        logic           wb_out;
        logic [2:0]     wba;
        logic [15:0]    wbd;
        logic [31:0]    pc;
        logic [2:0]     fl;
        int             unstable;
        int             timeout;
    } res_t;

    typedef struct {
        op_t         op;
        int          d0;
        logic [15:0] r0;
        int          exp_stall;
        int          exp_nacc;
        logic [11:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_wd;
        logic [15:0] exp_wbd;
        logic        exp_wbo;
        logic [2:0]  exp_wba;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] data, input logic [31:0] addr,
                                  input logic [2:0] wba, input logic wb, input logic mr,
                                  input logic mw, input logic jwsp, input logic spc,
                                  input logic sfl, input logic [2:0] ff);
        op_t o;
        o.data = data; o.addr = addr; o.wba = wba; o.wb = wb; o.mr = mr; o.mw = mw;
        o.jwsp = jwsp; o.spc = spc; o.sfl = sfl; o.ff = ff;
        return o;
    endfunction

    // Drives one instruction, plays the memory side with per-word ack delays,
    // and records what the DUT did until one cycle past its write-back pulse.
    task automatic run_op(input op_t op, input int d0, input int d1,
                          input logic [15:0] r0, input logic [15:0] r1,
                          input bit stray, output res_t res);
        int word = 0;
        int wait_cnt = 0;
        bit done = 0, fin = 0, prev_stall = 1, hold = 0;
        logic [11:0] ha;
        logic        hw;
        logic [15:0] hd;
        res = '{default: 0};
        ha = '0; hw = 1'b0; hd = '0;
        @(posedge clk); #1;
        ex_valid = 1'b1; Data = op.data; Address = op.addr; WB_Address = op.wba;
        WB = op.wb; MR = op.mr; MW = op.mw; JWSP = op.jwsp; Stack_PC = op.spc;
        Stack_Flags = op.sfl; Final_Flags = op.ff;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (!prev_stall) ex_valid = 1'b0;
            end
            if (mem_req) begin
                mem_ack   = (wait_cnt == ((word == 0) ? d0 : d1));
                mem_rdata = mem_ack ? ((word == 0) ? r0 : r1) : 16'($urandom);
            end else begin
                mem_ack   = stray && ($urandom_range(0, 2) == 0);
                mem_rdata = 16'($urandom);
            end
            @(negedge clk);
            prev_stall = Stall;
            if (Stall) res.stall++;
            if (wb_valid) begin
                res.n_wbv++;
                res.wb_out = WB_Out; res.wba = WB_Address_Out; res.wbd = WB_Data;
            end
            if (PC_Load) begin res.n_pcl++; res.pc = PC_From_Memory; end
            if (Flags_Restore) begin res.n_flr++; res.fl = Flags_From_Memory; end
            if (mem_req) begin
                if (hold && (mem_addr !== ha || mem_we !== hw || mem_wdata !== hd))
                    res.unstable++;
                ha = mem_addr; hw = mem_we; hd = mem_wdata; hold = 1;
                if (mem_ack) begin
                    if (word < 2) begin
                        res.a_addr[word] = mem_addr;
                        res.a_we[word]   = mem_we;
                        res.a_wd[word]   = mem_wdata;
                    end
                    res.n_acc++; word++; wait_cnt = 0; hold = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (done) fin = 1;
            else if (wb_valid) done = 1;
        end
        if (!fin) res.timeout = 1;
        mem_ack = 1'b0;
        ex_valid = 1'b0;
    endtask

    // Expected behaviour derived from the op class: access list, stall length, results.
    function automatic res_t model(input op_t op, input int d0, input int d1,
                                   input logic [15:0] r0, input logic [15:0] r1);
        res_t e;
        logic mem, dbl, rd;
        logic [31:0] a1;
        e = '{default: 0};
        mem = op.mr | op.mw;
        dbl = op.spc | op.jwsp;
        rd  = op.mr & !op.mw;
        e.n_wbv  = 1;
        e.wba    = op.wba;
        e.wb_out = op.wb & !(dbl | op.sfl);
        e.wbd    = op.data[15:0];
        if (mem) begin
            a1 = op.addr + 32'd1;
            e.n_acc = dbl ? 2 : 1;
            e.stall = dbl ? (3 + d0 + d1) : (1 + d0);
            e.a_addr[0] = op.addr[11:0];
            e.a_addr[1] = a1[11:0];
            e.a_we[0] = op.mw;
            e.a_we[1] = dbl & op.mw;
            if (dbl) begin
                e.a_wd[0] = op.data[31:16];
                e.a_wd[1] = op.data[15:0];
            end else if (op.sfl) begin
                e.a_wd[0] = {13'b0, op.ff};
            end else begin
                e.a_wd[0] = op.data[15:0];
            end
            if (rd && !dbl && !op.sfl) e.wbd = r0;
            if (rd && op.spc) begin e.n_pcl = 1; e.pc = {r0, r1}; end
            if (rd && op.sfl && !dbl) begin e.n_flr = 1; e.fl = r0[2:0]; end
        end
        return e;
    endfunction

    task automatic compare(input string p, input res_t r, input res_t e);
        check({p, ".timeout"}, 64'(r.timeout), 64'(0));
        check({p, ".n_acc"}, 64'(r.n_acc), 64'(e.n_acc));
        check({p, ".stall"}, 64'(r.stall), 64'(e.stall));
        check({p, ".wb_valid"}, 64'(r.n_wbv), 64'(e.n_wbv));
        check({p, ".WB_Out"}, 64'(r.wb_out), 64'(e.wb_out));
        check({p, ".WB_Address_Out"}, 64'(r.wba), 64'(e.wba));
        check({p, ".WB_Data"}, 64'(r.wbd), 64'(e.wbd));
        check({p, ".PC_Load"}, 64'(r.n_pcl), 64'(e.n_pcl));
        check({p, ".Flags_Restore"}, 64'(r.n_flr), 64'(e.n_flr));
        check({p, ".unstable"}, 64'(r.unstable), 64'(0));
        for (int i = 0; i < e.n_acc && i < 2; i++) begin
            check($sformatf("%s.addr%0d", p, i), 64'(r.a_addr[i]), 64'(e.a_addr[i]));
            check($sformatf("%s.we%0d", p, i), 64'(r.a_we[i]), 64'(e.a_we[i]));
            if (e.a_we[i])
                check($sformatf("%s.wdata%0d", p, i), 64'(r.a_wd[i]), 64'(e.a_wd[i]));
        end
        if (e.n_pcl > 0) check({p, ".PC_From_Memory"}, 64'(r.pc), 64'(e.pc));
        if (e.n_flr > 0) check({p, ".Flags_From_Memory"}, 64'(r.fl), 64'(e.fl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        res_t r;
        op_t  op;
        bit   acked, in_acc1;

        vecs[0] = '{mk_op(32'd15, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0),
                    0, 16'h0, 0, 0, 12'h0, 1'b0, 16'h0, 16'h000F, 1'b1, 3'd7};
        vecs[1] = '{mk_op(32'hABCD_1234, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0),
                    0, 16'h0, 0, 0, 12'h0, 1'b0, 16'h0, 16'h1234, 1'b0, 3'd3};
        vecs[2] = '{mk_op(32'h5555_AAAA, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0),
                    0, 16'h0, 0, 0, 12'h0, 1'b0, 16'h0, 16'hAAAA, 1'b0, 3'd2};
        vecs[3] = '{mk_op(32'h0, 32'h20, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0),
                    3, 16'hBEEF, 4, 1, 12'h020, 1'b0, 16'h0, 16'hBEEF, 1'b1, 3'd5};
        vecs[4] = '{mk_op(32'h0000_CAFE, 32'h0012_3456, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0),
                    1, 16'h0, 2, 1, 12'h456, 1'b1, 16'hCAFE, 16'hCAFE, 1'b0, 3'd4};
        vecs[5] = '{mk_op(32'h0000_7777, 32'h0ABC, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0),
                    0, 16'h0, 1, 1, 12'hABC, 1'b1, 16'h7777, 16'h7777, 1'b1, 3'd1};

        rst = 1'b1; ex_valid = 1'b0; Data = '0; WB_Address = '0; MR = 1'b0; MW = 1'b0;
        WB = 1'b0; Address = '0; JWSP = 1'b0; Stack_PC = 1'b0; Stack_Flags = 1'b0;
        Final_Flags = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.mem_req", 64'(mem_req), 64'(0));
        check("reset.mem_we", 64'(mem_we), 64'(0));
        check("reset.mem_addr", 64'(mem_addr), 64'(0));
        check("reset.mem_wdata", 64'(mem_wdata), 64'(0));
        check("reset.Stall", 64'(Stall), 64'(0));
        check("reset.wb_valid", 64'(wb_valid), 64'(0));
        check("reset.wb_fields", 64'({WB_Out, WB_Address_Out, WB_Data}), 64'(0));
        check("reset.restore", 64'({Flags_From_Memory, Flags_Restore, PC_Load}), 64'(0));
        check("reset.PC_From_Memory", 64'(PC_From_Memory), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            string p;
            p = $sformatf("vec%0d", i);
            run_op(vecs[i].op, vecs[i].d0, 0, vecs[i].r0, 16'h0, 1'b1, r);
            check({p, ".timeout"}, 64'(r.timeout), 64'(0));
            check({p, ".stall"}, 64'(r.stall), 64'(vecs[i].exp_stall));
            check({p, ".n_acc"}, 64'(r.n_acc), 64'(vecs[i].exp_nacc));
            check({p, ".wb_valid"}, 64'(r.n_wbv), 64'(1));
            check({p, ".WB_Data"}, 64'(r.wbd), 64'(vecs[i].exp_wbd));
            check({p, ".WB_Out"}, 64'(r.wb_out), 64'(vecs[i].exp_wbo));
            check({p, ".WB_Address_Out"}, 64'(r.wba), 64'(vecs[i].exp_wba));
            if (vecs[i].exp_nacc > 0) begin
                check({p, ".mem_addr"}, 64'(r.a_addr[0]), 64'(vecs[i].exp_addr));
                check({p, ".mem_we"}, 64'(r.a_we[0]), 64'(vecs[i].exp_we));
                if (vecs[i].exp_we)
                    check({p, ".mem_wdata"}, 64'(r.a_wd[0]), 64'(vecs[i].exp_wd));
            end
        end

        op = mk_op(32'h0001_0002, 32'h3FE, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        run_op(op, 0, 0, 16'h0, 16'h0, 1'b1, r);
        check("jwsp.n_acc", 64'(r.n_acc), 64'(2));
        check("jwsp.addr0", 64'(r.a_addr[0]), 64'(12'h3FE));
        check("jwsp.wdata0", 64'(r.a_wd[0]), 64'(16'h0001));
        check("jwsp.addr1", 64'(r.a_addr[1]), 64'(12'h3FF));
        check("jwsp.wdata1", 64'(r.a_wd[1]), 64'(16'h0002));
        check("jwsp.we", 64'(r.a_we), 64'(2'b11));
        check("jwsp.stall", 64'(r.stall), 64'(3));
        check("jwsp.WB_Out", 64'(r.wb_out), 64'(0));
        check("jwsp.wb_valid", 64'(r.n_wbv), 64'(1));

        op = mk_op(32'h0, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        run_op(op, 1, 2, 16'h1234, 16'h5678, 1'b1, r);
        check("pop_pc.addr0", 64'(r.a_addr[0]), 64'(12'hFFF));
        check("pop_pc.addr1", 64'(r.a_addr[1]), 64'(12'h000));
        check("pop_pc.PC_From_Memory", 64'(r.pc), 64'(32'h1234_5678));
        check("pop_pc.PC_Load", 64'(r.n_pcl), 64'(1));
        check("pop_pc.stall", 64'(r.stall), 64'(6));

        op = mk_op(32'h0, 32'h100, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101);
        run_op(op, 0, 0, 16'h0, 16'h0, 1'b1, r);
        check("push_fl.n_acc", 64'(r.n_acc), 64'(1));
        check("push_fl.wdata", 64'(r.a_wd[0]), 64'(16'h0005));
        op = mk_op(32'h0, 32'h100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        run_op(op, 2, 0, 16'h0006, 16'h0, 1'b1, r);
        check("pop_fl.Flags_From_Memory", 64'(r.fl), 64'(3'b110));
        check("pop_fl.Flags_Restore", 64'(r.n_flr), 64'(1));
        check("pop_fl.PC_Load", 64'(r.n_pcl), 64'(0));

        for (int it = 0; it < 40; it++) begin
            int k, d0, d1;
            logic [15:0] r0, r1;
            res_t e;
            k = int'($urandom_range(0, 7));
            op = mk_op($urandom, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 1))) : $urandom,
                       3'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom));
            case (k)
                1: op.mr = 1'b1;
                2: op.mw = 1'b1;
                3: begin op.mw = 1'b1; op.jwsp = 1'b1; end
                4: begin op.mr = 1'b1; op.spc = 1'b1; end
                5: begin op.mw = 1'b1; op.sfl = 1'b1; end
                6: begin op.mr = 1'b1; op.sfl = 1'b1; end
                7: begin op.mr = 1'b1; op.mw = 1'b1; end
                default: ;
            endcase
            d0 = int'($urandom_range(0, 3));
            d1 = int'($urandom_range(0, 3));
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            run_op(op, d0, d1, r0, r1, 1'b1, r);
            e = model(op, d0, d1, r0, r1);
            compare($sformatf("rnd%0d_k%0d", it, k), r, e);
        end

        op = mk_op(32'h0, 32'h40, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        @(posedge clk); #1;
        ex_valid = 1'b1; Data = op.data; Address = op.addr; WB_Address = op.wba;
        WB = op.wb; MR = op.mr; MW = op.mw; JWSP = op.jwsp; Stack_PC = op.spc;
        Stack_Flags = op.sfl; Final_Flags = op.ff;
        acked = 0; in_acc1 = 0;
        for (int c = 0; c < 20 && !in_acc1; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                ex_valid = 1'b0;
            end
            if (mem_req && !acked) begin
                mem_ack = 1'b1; mem_rdata = 16'h1111;
            end else begin
                mem_ack = 1'b0;
                if (mem_req && acked) in_acc1 = 1;
            end
            if (!in_acc1) begin
                @(negedge clk);
                if (mem_req && mem_ack) acked = 1;
            end
        end
        check("rst_acc1.reached", 64'(in_acc1), 64'(1));
        rst = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h2222;
        @(negedge clk);
        check("rst_acc1.mem_req", 64'(mem_req), 64'(0));
        check("rst_acc1.Stall", 64'(Stall), 64'(0));
        check("rst_acc1.PC_Load", 64'(PC_Load), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("rst_late_ack%0d", c),
                  64'({mem_req, Stall, PC_Load, wb_valid}), 64'(0));
        end
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
